// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for one shared downstream resource: grant, hold, hold-limit release, one-cycle gap.
// Optional macro RR_ARB_LOCK_EN adds a lock input that suppresses the hold-limit release.
module rr_bus_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
`ifdef RR_ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           preempt
);

  localparam int HW = $clog2(MAX_HOLD);

  localparam logic [IDW:0]   N_W       = (IDW+1)'(N);
  localparam logic [IDW-1:0] ID_ONE    = IDW'(1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);
  localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [N-1:0]   ONE_HOT0  = N'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e         state_q;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q;
  logic           busy_q;
  logic           preempt_q;
  logic [IDW-1:0] ptr_q;
  logic [HW-1:0]  hold_cnt_q;

  logic           arb_vld_d;
  logic [IDW-1:0] arb_id_d;
  logic [IDW-1:0] ptr_d;
  logic           owner_req_s;

  // Circular first-set search starting at p; returns {valid, index}.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic           found;
    logic [IDW-1:0] sel;
    logic [IDW:0]   cand;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      cand  = {1'b0, p} + (IDW+1)'(k);
      cand  = (cand >= N_W) ? (cand - N_W) : cand;
      sel   = (!found && r[cand[IDW-1:0]]) ? cand[IDW-1:0] : sel;
      found = found | r[cand[IDW-1:0]];
    end
    return {found, sel};
  endfunction

  // Arbitration result, pointer successor of the current owner, and owner request sample.
  always_comb begin
    {arb_vld_d, arb_id_d} = rr_pick(req, ptr_q);
    if (grant_id_q == ID_LAST) begin
      ptr_d = '0;
    end else begin
      ptr_d = grant_id_q + ID_ONE;
    end
    owner_req_s = req[grant_id_q];
  end

  // Ownership FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_GAP: begin
          hold_cnt_q <= '0;
          if (arb_vld_d) begin
            state_q    <= ST_GRANT;
            grant_q    <= ONE_HOT0 << arb_id_d;
            grant_id_q <= arb_id_d;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!owner_req_s) begin
            state_q    <= ST_GAP;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= ptr_d;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
`ifdef RR_ARB_LOCK_EN
            if (lock) begin
              hold_cnt_q <= HOLD_LAST;
            end else begin
              state_q    <= ST_GAP;
              grant_q    <= '0;
              grant_id_q <= '0;
              busy_q     <= 1'b0;
              preempt_q  <= 1'b1;
              ptr_q      <= ptr_d;
              hold_cnt_q <= '0;
            end
`else
            state_q    <= ST_GAP;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b1;
            ptr_q      <= ptr_d;
            hold_cnt_q <= '0;
`endif
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_ONE;
          end
        end
        default: begin
          // Unused encoding: fall back to a clean idle with no owner.
          state_q    <= ST_IDLE;
          grant_q    <= '0;
          grant_id_q <= '0;
          busy_q     <= 1'b0;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter (N=4, MAX_HOLD=8): vector table plus reset, glitch and lock sequences.
module tb_rr_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
`ifdef RR_ARB_LOCK_EN
  logic       lock;
`endif
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       preempt;

  int n_cmp;
  int n_err;

  rr_bus_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
`ifdef RR_ARB_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] id;
    logic       pre;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id, input logic pre);
    vec_t v;
    v.req = r; v.g = g; v.id = id; v.pre = pre;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] id, input logic pre);
    logic exp_busy;
    exp_busy = (g != 4'b0000);
    n_cmp++;
    if (grant !== g || grant_id !== id || busy !== exp_busy || preempt !== pre) begin
      n_err++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b preempt=%b, want grant=%b id=%0d busy=%b preempt=%b",
               name, grant, grant_id, busy, preempt, g, id, exp_busy, pre);
    end
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b1111;
`ifdef RR_ARB_LOCK_EN
    lock  = 1'b0;
`endif

    // Vector table: state after each edge.
    add(4'b1111, 4'b0001, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) add(4'b0100, 4'b0100, 2'd2, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // Round robin from ptr=3, each owner drops its request on its third edge.
    add(4'b1111, 4'b1000, 2'd3, 1'b0); add(4'b1111, 4'b1000, 2'd3, 1'b0); add(4'b0111, 4'b0000, 2'd0, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b0); add(4'b1111, 4'b0001, 2'd0, 1'b0); add(4'b1110, 4'b0000, 2'd0, 1'b0);
    add(4'b1111, 4'b0010, 2'd1, 1'b0); add(4'b1111, 4'b0010, 2'd1, 1'b0); add(4'b1101, 4'b0000, 2'd0, 1'b0);
    add(4'b1111, 4'b0100, 2'd2, 1'b0); add(4'b1111, 4'b0100, 2'd2, 1'b0); add(4'b1011, 4'b0000, 2'd0, 1'b0);
    add(4'b1111, 4'b1000, 2'd3, 1'b0); add(4'b1111, 4'b1000, 2'd3, 1'b0); add(4'b0111, 4'b0000, 2'd0, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b0010, 4'b0010, 2'd1, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // Hold limit: ptr=2, req 0011 -> owner 0 for 8 cycles, preempt, owner 1 for 8, preempt, owner 0.
    for (int i = 0; i < 8; i++) add(4'b0011, 4'b0001, 2'd0, 1'b0);
    add(4'b0011, 4'b0000, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) add(4'b0011, 4'b0010, 2'd1, 1'b0);
    add(4'b0011, 4'b0000, 2'd0, 1'b1);
    add(4'b0011, 4'b0001, 2'd0, 1'b0);
    // Sole requester is preempted but regains the bus after the gap.
    for (int i = 0; i < 7; i++) add(4'b0001, 4'b0001, 2'd0, 1'b0);
    add(4'b0001, 4'b0000, 2'd0, 1'b1);
    add(4'b0001, 4'b0001, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);

    // Reset held with all requests active.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", 4'b0000, 2'd0, 1'b0);

    foreach (vq[i]) begin
      step(vq[i].req);
      check($sformatf("vec%0d", i), vq[i].g, vq[i].id, vq[i].pre);
    end

    // Asynchronous reset while requester 3 owns the bus (ptr=1 here).
    step(4'b1000);
    check("own3_before_reset", 4'b1000, 2'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    req   = 4'b1001;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ptr0", 4'b0001, 2'd0, 1'b0);
    step(4'b0000);
    check("post_reset_gap", 4'b0000, 2'd0, 1'b0);
    step(4'b0000);
    check("post_reset_idle", 4'b0000, 2'd0, 1'b0);

    // Sub-cycle request pulse between edges is never granted.
    @(negedge clk);
    req = 4'b0100;
    #2;
    req = 4'b0000;
    @(posedge clk);
    #1;
    check("glitch_ignored", 4'b0000, 2'd0, 1'b0);
    step(4'b0000);
    check("glitch_still_idle", 4'b0000, 2'd0, 1'b0);

`ifdef RR_ARB_LOCK_EN
    // ptr=1: requester 1 wins, lock keeps it past the hold limit.
    lock = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(4'b0011);
      check($sformatf("lock_hold%0d", i), 4'b0010, 2'd1, 1'b0);
    end
    @(negedge clk);
    lock = 1'b0;
    @(posedge clk);
    #1;
    check("lock_release_preempt", 4'b0000, 2'd0, 1'b1);
    step(4'b0011);
    check("lock_next_owner", 4'b0001, 2'd0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
